// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and helpers for the fetch queue unit.
// Optional build macro used across the slice: FQ_PERF_EN (performance counters).
package fetch_queue_unit_pkg;

  localparam int unsigned ALEN = 32;
  localparam int unsigned XLEN = 32;

  // One decoded-side packet: slot address, predicted next address, raw bits and
  // the predictor information that rides along to writeback.
  typedef struct packed {
    logic [ALEN-1:0] pc;
    logic [ALEN-1:0] npc;
    logic [XLEN-1:0] inst;
    logic            valid;
    logic            bp_hit;
    logic            bp_taken;
    logic [1:0]      bp_state;
  } If_id_pkt_t;

  // Width of a ring pointer for a queue of the given depth.
  function automatic int unsigned fq_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch-side/decode-side bus of the fetch queue unit.
// master: memory/predictor/decode environment; slave: fetch_queue_unit.
interface fetch_queue_unit_if #(
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned DEC_W   = 2
);
  import fetch_queue_unit_pkg::*;

  localparam int unsigned CW = $clog2(DEC_W + 1);

  logic                             redirect;
  logic [ALEN-1:0]                  redirect_addr;
  logic [FETCH_W-1:0]               bp_hit;
  logic [FETCH_W-1:0]               bp_taken;
  logic [1:0]                       bp_state;
  logic [ALEN-1:0]                  bp_target;
  logic [FETCH_W-1:0][XLEN-1:0]     inst;
  logic [FETCH_W-1:0][ALEN-1:0]     fetch_pc;
  If_id_pkt_t [DEC_W-1:0]           dec_pkt;
  logic [DEC_W-1:0]                 dec_valid;
  logic [CW-1:0]                    dec_consume;

  modport master (
    output redirect, redirect_addr, bp_hit, bp_taken, bp_state, bp_target,
           inst, dec_consume,
    input  fetch_pc, dec_pkt, dec_valid
  );

  modport slave (
    input  redirect, redirect_addr, bp_hit, bp_taken, bp_state, bp_target,
           inst, dec_consume,
    output fetch_pc, dec_pkt, dec_valid
  );

endinterface

// File: rtl/fetch_queue_unit_fq_ring.sv
// Circular fetch queue: up to FETCH_W writes and DEC_W reads per cycle,
// head/tail/count bookkeeping and a single-cycle flush.
module fq_ring
  import fetch_queue_unit_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned DEC_W   = 2,
  localparam int unsigned PW     = fq_ptr_w(DEPTH),
  localparam int unsigned CNTW   = PW + 1,
  localparam int unsigned ECW    = $clog2(FETCH_W + 1),
  localparam int unsigned DCW    = $clog2(DEC_W + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [ECW-1:0]         enq_cnt,
  input  If_id_pkt_t [FETCH_W-1:0] enq_pkt,
  input  logic [DCW-1:0]         deq_req,
  output logic [CNTW-1:0]        count,
  output If_id_pkt_t [DEC_W-1:0] head_pkt,
  output logic [DEC_W-1:0]       head_valid
);

  If_id_pkt_t      mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CNTW-1:0] deq_cnt;

  // Dequeue amount, clamped to the number of live entries.
  always_comb begin
    deq_cnt = CNTW'(deq_req);
    if (deq_cnt > count) deq_cnt = count;
  end

  // Pointer and occupancy update; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq_cnt);
      tail  <= tail + PW'(enq_cnt);
      count <= count + CNTW'(enq_cnt) - deq_cnt;
    end
  end

  // Storage write: live slots land at consecutive positions from tail.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int unsigned i = 0; i < FETCH_W; i++) begin
        if (ECW'(i) < enq_cnt) mem[tail + PW'(i)] <= enq_pkt[i];
      end
    end
  end

  // Head window; empty positions read as zero so stale entries never leak out.
  always_comb begin
    head_pkt   = '0;
    head_valid = '0;
    for (int unsigned j = 0; j < DEC_W; j++) begin
      head_valid[j] = CNTW'(j) < count;
      if (head_valid[j]) head_pkt[j] = mem[head + PW'(j)];
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// N-wide instruction fetch with a decoupling fetch queue.
// Define FQ_PERF_EN to add saturating perf_fetched/perf_stall_cyc/perf_redirects.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int unsigned     FETCH_W    = 2,
  parameter int unsigned     DEC_W      = 2,
  parameter int unsigned     FQ_DEPTH   = 8,
  parameter int unsigned     INST_BYTES = 2,
  parameter logic [ALEN-1:0] RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               rst,
  fetch_queue_unit_if.slave  fq
`ifdef FQ_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall_cyc,
  output logic [31:0]        perf_redirects
`endif
);

  localparam int unsigned PW   = fq_ptr_w(FQ_DEPTH);
  localparam int unsigned CNTW = PW + 1;
  localparam int unsigned ECW  = $clog2(FETCH_W + 1);

  logic [ALEN-1:0]          pc;
  logic [ALEN-1:0]          pc_next;
  logic [CNTW-1:0]          count;
  logic                     stall;
  logic                     any_taken;
  logic [ECW-1:0]           live_cnt;
  logic [ECW-1:0]           enq_cnt;
  If_id_pkt_t [FETCH_W-1:0] enq_pkt;

  // Sequential slot addresses for memory and predictor.
  always_comb begin
    for (int unsigned i = 0; i < FETCH_W; i++) begin
      fq.fetch_pc[i] = pc + ALEN'(i * INST_BYTES);
    end
  end

  // Build packets and truncate the group after the first predicted-taken slot.
  always_comb begin
    any_taken = 1'b0;
    live_cnt  = ECW'(FETCH_W);
    enq_pkt   = '0;
    for (int unsigned i = 0; i < FETCH_W; i++) begin
      enq_pkt[i].pc       = fq.fetch_pc[i];
      enq_pkt[i].npc      = fq.fetch_pc[i] + ALEN'(INST_BYTES);
      enq_pkt[i].inst     = fq.inst[i];
      enq_pkt[i].valid    = 1'b1;
      enq_pkt[i].bp_hit   = fq.bp_hit[i];
      enq_pkt[i].bp_taken = fq.bp_taken[i];
      enq_pkt[i].bp_state = fq.bp_state;
      if (!any_taken && fq.bp_taken[i]) begin
        any_taken      = 1'b1;
        live_cnt       = ECW'(i + 1);
        enq_pkt[i].npc = fq.bp_target;
      end
    end
  end

  // Stall on the start-of-cycle occupancy; a same-cycle dequeue earns no credit.
  always_comb begin
    stall   = (CNTW'(FQ_DEPTH) - count) < CNTW'(FETCH_W);
    enq_cnt = (stall || fq.redirect) ? '0 : live_cnt;
  end

  // Next fetch address in priority order.
  always_comb begin
    if (fq.redirect)   pc_next = fq.redirect_addr;
    else if (stall)    pc_next = pc;
    else if (any_taken) pc_next = fq.bp_target;
    else               pc_next = pc + ALEN'(FETCH_W * INST_BYTES);
  end

  // Fetch address register.
  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end

  fq_ring #(
    .DEPTH   (FQ_DEPTH),
    .FETCH_W (FETCH_W),
    .DEC_W   (DEC_W)
  ) u_ring (
    .clk        (clk),
    .rst        (rst),
    .flush      (fq.redirect),
    .enq_cnt    (enq_cnt),
    .enq_pkt    (enq_pkt),
    .deq_req    (fq.dec_consume),
    .count      (count),
    .head_pkt   (fq.dec_pkt),
    .head_valid (fq.dec_valid)
  );

`ifdef FQ_PERF_EN
  logic [32:0] fetched_sum;

  // Wide sum so an overflowing add can be pinned at all-ones.
  always_comb begin
    fetched_sum = {1'b0, perf_fetched} + 33'(enq_cnt);
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched   <= '0;
      perf_stall_cyc <= '0;
      perf_redirects <= '0;
    end else begin
      perf_fetched <= fetched_sum[32] ? '1 : fetched_sum[31:0];
      if (stall && perf_stall_cyc != '1)       perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (fq.redirect && perf_redirects != '1) perf_redirects <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule
